// File: rtl/alu_op_sequencer.sv
// Command sequencer for a shared 4-bit ALU, with a shift-add 4x4 multiply.
// Optional result counter: define ALU_SEQ_OPCOUNT_EN to add OpCount.
module alu_op_sequencer #(
   parameter int MUL_ITERS = 4
) (
   input  logic       Clock,
   input  logic       Reset_b,
   input  logic       CmdValid,
   output logic       CmdReady,
   input  logic [2:0] CmdOp,
   input  logic [3:0] CmdA,
   input  logic [3:0] CmdB,
   output logic [3:0] AluA,
   output logic [3:0] AluB,
   output logic [2:0] AluFunction,
   input  logic [7:0] AluOut,
   output logic       ResValid,
   input  logic       ResReady,
   output logic [7:0] Result,
   output logic       ResErr,
   output logic       Busy
`ifdef ALU_SEQ_OPCOUNT_EN
   ,
   output logic [7:0] OpCount
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL,
      DONE
   } state_t;

   localparam logic [2:0] LAST_ITER = 3'(MUL_ITERS - 1);

   state_t     state;
   logic [3:0] mcand;
   logic [3:0] phi;
   logic [3:0] plo;
   logic [2:0] iter;
   logic [3:0] phi_n;
   logic [3:0] plo_n;
   logic       accept;

   assign CmdReady = (state == IDLE) & Reset_b;
   assign Busy     = (state != IDLE);
   assign accept   = CmdValid & CmdReady;

   // 5-bit add result joined with Plo, shifted right by one
   always_comb begin
      phi_n = AluOut[4:1];
      plo_n = {AluOut[0], plo[3:1]};
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         state       <= IDLE;
         mcand       <= '0;
         phi         <= '0;
         plo         <= '0;
         iter        <= '0;
         AluA        <= '0;
         AluB        <= '0;
         AluFunction <= '0;
         Result      <= '0;
         ResErr      <= 1'b0;
         ResValid    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  unique case (1'b1)
                     (CmdOp == 3'b110): begin
                        mcand       <= CmdA;
                        plo         <= CmdB;
                        phi         <= '0;
                        iter        <= '0;
                        AluFunction <= 3'b001;
                        AluA        <= '0;
                        AluB        <= CmdB[0] ? CmdA : 4'h0;
                        state       <= MUL;
                     end
                     (CmdOp == 3'b111): begin
                        Result   <= '0;
                        ResErr   <= 1'b1;
                        ResValid <= 1'b1;
                        state    <= DONE;
                     end
                     default: begin
                        AluA        <= CmdA;
                        AluB        <= CmdB;
                        AluFunction <= CmdOp;
                        state       <= EXEC;
                     end
                  endcase
               end
            end
            EXEC: begin
               Result   <= AluOut;
               ResErr   <= 1'b0;
               ResValid <= 1'b1;
               state    <= DONE;
            end
            MUL: begin
               phi  <= phi_n;
               plo  <= plo_n;
               AluA <= phi_n;
               AluB <= plo_n[0] ? mcand : 4'h0;
               iter <= iter + 3'd1;
               if (iter == LAST_ITER) begin
                  Result   <= {phi_n, plo_n};
                  ResErr   <= 1'b0;
                  ResValid <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (ResReady) begin
                  ResValid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_OPCOUNT_EN
   // Saturating count of completed result handshakes
   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         OpCount <= '0;
      end else if (ResValid && ResReady && OpCount != 8'hFF) begin
         OpCount <= OpCount + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU.
// Covers ALU passthrough, MUL, illegal ops, back-pressure and reset.
module tb_alu_op_sequencer;

   typedef struct {
      logic [7:0] res;
      logic       err;
   } exp_t;

   logic       Clock;
   logic       Reset_b;
   logic       CmdValid;
   logic       CmdReady;
   logic [2:0] CmdOp;
   logic [3:0] CmdA;
   logic [3:0] CmdB;
   logic [3:0] AluA;
   logic [3:0] AluB;
   logic [2:0] AluFunction;
   logic [7:0] AluOut;
   logic       ResValid;
   logic       ResReady;
   logic [7:0] Result;
   logic       ResErr;
   logic       Busy;
`ifdef ALU_SEQ_OPCOUNT_EN
   logic [7:0] OpCount;
   logic [7:0] mcnt;
`endif

   int   total;
   int   bad;
   exp_t sb[$];

   alu_op_sequencer dut (
      .Clock      (Clock),
      .Reset_b    (Reset_b),
      .CmdValid   (CmdValid),
      .CmdReady   (CmdReady),
      .CmdOp      (CmdOp),
      .CmdA       (CmdA),
      .CmdB       (CmdB),
      .AluA       (AluA),
      .AluB       (AluB),
      .AluFunction(AluFunction),
      .AluOut     (AluOut),
      .ResValid   (ResValid),
      .ResReady   (ResReady),
      .Result     (Result),
      .ResErr     (ResErr),
      .Busy       (Busy)
`ifdef ALU_SEQ_OPCOUNT_EN
      ,
      .OpCount    (OpCount)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [7:0] alu_fn(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic [2:0] f
   );
      case (f)
         3'd0:    return {4'h0, a & b};
         3'd1:    return 8'(a) + 8'(b);
         3'd2:    return 8'(a) - 8'(b);
         3'd3:    return {4'h0, a | b};
         3'd4:    return {4'h0, a ^ b};
         3'd5:    return {a, b};
         default: return 8'h00;
      endcase
   endfunction

   always_comb AluOut = alu_fn(AluA, AluB, AluFunction);

   function automatic exp_t model(
      input logic [2:0] op,
      input logic [3:0] a,
      input logic [3:0] b
   );
      exp_t e;
      e.err = 1'b0;
      if (op == 3'd7) begin
         e.res = 8'h00;
         e.err = 1'b1;
      end else if (op == 3'd6) begin
         e.res = 8'(a) * 8'(b);
      end else begin
         e.res = alu_fn(a, b, op);
      end
      return e;
   endfunction

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pop on every result handshake
   always @(negedge Clock) begin
      exp_t e;
      if (Reset_b && ResValid && ResReady) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("result", 32'(Result), 32'(e.res));
            check("res_err", 32'(ResErr), 32'(e.err));
         end
`ifdef ALU_SEQ_OPCOUNT_EN
         check("opcount", 32'(OpCount), 32'(mcnt));
         if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
`endif
      end
   end

   task automatic send(
      input logic [2:0] op,
      input logic [3:0] a,
      input logic [3:0] b,
      input bit         drain
   );
      int   n;
      int   lat;
      int   want;
      @(negedge Clock);
      CmdValid = 1'b1;
      CmdOp    = op;
      CmdA     = a;
      CmdB     = b;
      n = 0;
      while (!CmdReady && n < 50) begin
         @(negedge Clock);
         n++;
      end
      if (!CmdReady) begin
         check("accept_timeout", 32'(CmdReady), 32'd1);
         CmdValid = 1'b0;
         return;
      end
      sb.push_back(model(op, a, b));
      @(posedge Clock);
      #1 CmdValid = 1'b0;
      @(negedge Clock);
      check("busy_run", 32'(Busy), 32'd1);
      if (op == 3'd6) begin
         check("mul_f", 32'(AluFunction), 32'd1);
         check("mul_a", 32'(AluA), 32'd0);
         check("mul_b", 32'(AluB), 32'(b[0] ? a : 4'h0));
      end else if (op != 3'd7) begin
         check("alu_f", 32'(AluFunction), 32'(op));
         check("alu_a", 32'(AluA), 32'(a));
         check("alu_b", 32'(AluB), 32'(b));
      end
      lat = 1;
      while (!ResValid && lat < 20) begin
         @(negedge Clock);
         lat++;
      end
      want = (op == 3'd7) ? 1 : ((op == 3'd6) ? 5 : 2);
      check("latency", 32'(lat), 32'(want));
      if (drain && ResReady) begin
         @(negedge Clock);
         check("busy_idle", 32'(Busy), 32'd0);
         check("rdy_back", 32'(CmdReady), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total    = 0;
      bad      = 0;
      Reset_b  = 1'b0;
      CmdValid = 1'b0;
      CmdOp    = '0;
      CmdA     = '0;
      CmdB     = '0;
      ResReady = 1'b1;
`ifdef ALU_SEQ_OPCOUNT_EN
      mcnt     = 8'h00;
`endif
      repeat (2) @(negedge Clock);
      check("rst_vld", 32'(ResValid), 32'd0);
      check("rst_res", 32'(Result), 32'd0);
      check("rst_err", 32'(ResErr), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_rdy", 32'(CmdReady), 32'd0);
      check("rst_alu", 32'({AluA, AluB, AluFunction}), 32'd0);
`ifdef ALU_SEQ_OPCOUNT_EN
      check("rst_opcnt", 32'(OpCount), 32'd0);
`endif
      Reset_b = 1'b1;

      send(3'd1, 4'hF, 4'h1, 1'b1);
`ifdef ALU_SEQ_OPCOUNT_EN
      check("opcnt_first", 32'(OpCount), 32'd1);
`endif
      send(3'd5, 4'h3, 4'hA, 1'b1);
      send(3'd6, 4'hF, 4'hF, 1'b1);
      send(3'd6, 4'h7, 4'h0, 1'b1);
      send(3'd6, 4'h6, 4'h5, 1'b1);
      send(3'd7, 4'h5, 4'h5, 1'b1);

      for (int i = 0; i < 40; i++) begin
         send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'b1);
      end

      // Back-pressure: result must hold and new commands be ignored
      ResReady = 1'b0;
      send(3'd6, 4'h9, 4'hB, 1'b0);
      CmdValid = 1'b1;
      CmdOp    = 3'd0;
      CmdA     = 4'h1;
      CmdB     = 4'h1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check("stall_vld", 32'(ResValid), 32'd1);
         check("stall_res", 32'(Result), 32'h63);
         check("stall_rdy", 32'(CmdReady), 32'd0);
         check("stall_busy", 32'(Busy), 32'd1);
      end
      CmdValid = 1'b0;
      @(posedge Clock);
      #1 ResReady = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      check("stall_rdy_back", 32'(CmdReady), 32'd1);
      check("stall_vld_low", 32'(ResValid), 32'd0);
      check("stall_sb", 32'(sb.size()), 32'd0);

`ifdef ALU_SEQ_OPCOUNT_EN
      for (int i = 0; i < 260; i++) send(3'd7, 4'h0, 4'h0, 1'b1);
      check("opcnt_sat", 32'(OpCount), 32'hFF);
`endif

      // Reset in the middle of a multiply
      @(negedge Clock);
      CmdValid = 1'b1;
      CmdOp    = 3'd6;
      CmdA     = 4'hF;
      CmdB     = 4'hF;
      check("mr_rdy", 32'(CmdReady), 32'd1);
      @(posedge Clock);
      #1 CmdValid = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1 check("mr_busy", 32'(Busy), 32'd1);
      #1 Reset_b = 1'b0;
      #1;
      check("mr_vld", 32'(ResValid), 32'd0);
      check("mr_res", 32'(Result), 32'd0);
      check("mr_busy0", 32'(Busy), 32'd0);
      check("mr_rdy0", 32'(CmdReady), 32'd0);
      check("mr_alu", 32'({AluA, AluB, AluFunction}), 32'd0);
`ifdef ALU_SEQ_OPCOUNT_EN
      check("mr_opcnt", 32'(OpCount), 32'd0);
      mcnt = 8'h00;
`endif
      @(negedge Clock);
      Reset_b = 1'b1;
      send(3'd0, 4'h2, 4'h3, 1'b1);
      send(3'd6, 4'h3, 4'h4, 1'b1);

      repeat (2) @(negedge Clock);
      check("sb_left", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
